// File: rtl/fifo_stream_sink.sv
// fifo_stream_sink: receiving end of the 256-bit fifo_stream conduit.
// Buffers DEPTH 256-bit words plus an end-of-packet flag and serializes each
// word into four 64-bit lanes behind a show-ahead read/empty/full port.
// Optional build macro: PACKET_GATE_EN - hold out_fifo_empty high until a
// complete packet is buffered (with a full-buffer escape to avoid deadlock).
//
// Read-side outputs (data/empty/last) are registered and computed from the
// next-cycle head pointer and lane, with a bypass of the incoming word when
// it lands directly at the head.

module fifo_stream_sink #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int PKT_CNT_W = 5
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic [255:0] fifo_data,
  input  logic         fifo_write,
  input  logic         fifo_send,
  output logic [63:0]  out_fifo_data,
  input  logic         out_fifo_read,
  output logic         out_fifo_empty,
  output logic         out_fifo_full,
  output logic         out_fifo_last,
  output logic         overflow
);

  localparam logic [ADDR_W:0]    LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]  LP_PINC  = ADDR_W'(1);
  localparam logic [PKT_CNT_W-1:0] LP_PONE = PKT_CNT_W'(1);

  logic [255:0]         r_mem [DEPTH];
  logic [DEPTH-1:0]     r_eop;
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [ADDR_W:0]      r_count;
  logic [1:0]           r_lane;
  logic [PKT_CNT_W-1:0] r_pkt_cnt;
  logic                 r_overflow;
  logic                 r_empty;
  logic                 r_last;
  logic [63:0]          r_data;

  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop_lane;
  logic                 w_pop_entry;
  logic [ADDR_W-1:0]    w_last_idx;
  logic                 w_flag_set;
  logic                 w_head_eop;
  logic                 w_pkt_inc;
  logic                 w_pkt_dec;
  logic [ADDR_W-1:0]    w_rd_ptr_nxt;
  logic [1:0]           w_lane_nxt;
  logic [ADDR_W:0]      w_count_nxt;
  logic [PKT_CNT_W-1:0] w_pkt_nxt;
  logic                 w_fwd;
  logic [255:0]         w_head_word_nxt;
  logic                 w_head_eop_nxt;
  logic [63:0]          w_data_nxt;
  logic                 w_empty_nxt;
  logic                 w_last_nxt;

`ifdef PACKET_GATE_EN
  logic                 r_in_pkt;
  logic                 w_in_pkt_nxt;
`endif

  // Push/pop qualification and the send-only flag update.
  always_comb begin
    w_push      = fifo_write && (r_count != LP_DEPTH);
    w_drop      = fifo_write && (r_count == LP_DEPTH);
    w_pop_lane  = out_fifo_read && !r_empty;
    w_pop_entry = w_pop_lane && (r_lane == 2'd3);
    w_last_idx  = r_wr_ptr - LP_PINC;
    // A send-only pulse cannot flag an entry that leaves the buffer this cycle.
    w_flag_set  = fifo_send && !fifo_write && (r_count != '0) &&
                  !r_eop[w_last_idx] && !(w_pop_entry && (r_count == LP_ONE));
    w_head_eop  = r_eop[r_rd_ptr];
    w_pkt_inc   = (w_push && fifo_send) || w_flag_set;
    w_pkt_dec   = w_pop_entry && w_head_eop;
  end

  // Next-state pointers, counts and the registered read-side view.
  always_comb begin
    w_rd_ptr_nxt = w_pop_entry ? (r_rd_ptr + LP_PINC) : r_rd_ptr;
    w_lane_nxt   = w_pop_lane ? (r_lane + 2'd1) : r_lane;

    w_count_nxt = r_count;
    unique case ({w_push, w_pop_entry})
      2'b10:   w_count_nxt = r_count + LP_ONE;
      2'b01:   w_count_nxt = r_count - LP_ONE;
      default: w_count_nxt = r_count;
    endcase

    w_pkt_nxt = r_pkt_cnt;
    unique case ({w_pkt_inc, w_pkt_dec})
      2'b10:   w_pkt_nxt = r_pkt_cnt + LP_PONE;
      2'b01:   w_pkt_nxt = r_pkt_cnt - LP_PONE;
      default: w_pkt_nxt = r_pkt_cnt;
    endcase

    // The pushed word becomes the head when it lands on the next read slot.
    w_fwd           = w_push && (r_wr_ptr == w_rd_ptr_nxt);
    w_head_word_nxt = w_fwd ? fifo_data : r_mem[w_rd_ptr_nxt];
    w_head_eop_nxt  = w_fwd ? fifo_send :
                      (r_eop[w_rd_ptr_nxt] || (w_flag_set && (w_last_idx == w_rd_ptr_nxt)));
    w_data_nxt      = w_head_word_nxt[{w_lane_nxt, 6'd0} +: 64];

`ifdef PACKET_GATE_EN
    w_in_pkt_nxt = r_in_pkt;
    if (w_count_nxt == '0)
      w_in_pkt_nxt = 1'b0;
    else if (w_pop_lane)
      w_in_pkt_nxt = !w_pkt_dec;
    w_empty_nxt = (w_count_nxt == '0) ||
                  !((w_pkt_nxt != '0) || (w_count_nxt == LP_DEPTH) || w_in_pkt_nxt);
`else
    w_empty_nxt = (w_count_nxt == '0);
`endif

    w_last_nxt = !w_empty_nxt && (w_lane_nxt == 2'd3) && w_head_eop_nxt;
  end

  // Word storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= fifo_data;
  end

  // Control state, eop flags and registered read-side outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_eop      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lane     <= 2'd0;
      r_pkt_cnt  <= '0;
      r_overflow <= 1'b0;
      r_empty    <= 1'b1;
      r_last     <= 1'b0;
      r_data     <= '0;
`ifdef PACKET_GATE_EN
      r_in_pkt   <= 1'b0;
`endif
    end else begin
      if (w_push)
        r_eop[r_wr_ptr] <= fifo_send;
      else if (w_flag_set)
        r_eop[w_last_idx] <= 1'b1;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + LP_PINC;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_lane     <= w_lane_nxt;
      r_count    <= w_count_nxt;
      r_pkt_cnt  <= w_pkt_nxt;
      r_overflow <= r_overflow | w_drop;
      r_empty    <= w_empty_nxt;
      r_last     <= w_last_nxt;
      r_data     <= w_data_nxt;
`ifdef PACKET_GATE_EN
      r_in_pkt   <= w_in_pkt_nxt;
`endif
    end
  end

  assign out_fifo_data  = r_data;
  assign out_fifo_empty = r_empty;
  assign out_fifo_last  = r_last;
  assign out_fifo_full  = (r_count == LP_DEPTH);
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_fifo_stream_sink.sv
// Directed bench for fifo_stream_sink. Inputs change 1 ns after the rising
// edge; outputs are sampled at the same point, i.e. showing the state that
// edge produced. Word built by mk(b) carries lane k = b + k.

module tb_fifo_stream_sink;

  logic         clk_clk = 1'b0;
  logic         reset_reset;
  logic [255:0] fifo_data;
  logic         fifo_write;
  logic         fifo_send;
  logic [63:0]  out_fifo_data;
  logic         out_fifo_read;
  logic         out_fifo_empty;
  logic         out_fifo_full;
  logic         out_fifo_last;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_clk = ~clk_clk;

  fifo_stream_sink #(.DEPTH(16), .ADDR_W(4), .PKT_CNT_W(5)) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .fifo_send     (fifo_send),
    .out_fifo_data (out_fifo_data),
    .out_fifo_read (out_fifo_read),
    .out_fifo_empty(out_fifo_empty),
    .out_fifo_full (out_fifo_full),
    .out_fifo_last (out_fifo_last),
    .overflow      (overflow)
  );

  function automatic logic [255:0] mk(input logic [63:0] b);
    return {b + 64'd3, b + 64'd2, b + 64'd1, b};
  endfunction

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] b, input logic snd);
    fifo_data  = mk(b);
    fifo_write = 1'b1;
    fifo_send  = snd;
    step();
    fifo_write = 1'b0;
    fifo_send  = 1'b0;
  endtask

  initial begin
    reset_reset   = 1'b1;
    fifo_data     = '0;
    fifo_write    = 1'b0;
    fifo_send     = 1'b0;
    out_fifo_read = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_data",  out_fifo_data, 64'd0);
    chk("rst_empty", 64'(out_fifo_empty), 64'd1);
    chk("rst_full",  64'(out_fifo_full), 64'd0);
    chk("rst_last",  64'(out_fifo_last), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    reset_reset = 1'b0;
    step();

    // Single flagged word, continuous read
    push(64'd1, 1'b1);
    chk("single_empty", 64'(out_fifo_empty), 64'd0);
    out_fifo_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("single_data", out_fifo_data, 64'(k + 1));
      chk("single_last", 64'(out_fifo_last), 64'(k == 3));
      step();
    end
    out_fifo_read = 1'b0;
    chk("single_empty_after", 64'(out_fifo_empty), 64'd1);
    chk("single_last_after", 64'(out_fifo_last), 64'd0);

    // Fill to DEPTH, overflow on the 17th, readback in order across wrap
    for (int i = 0; i < 16; i++) begin
      push(64'(1000 + 4 * i), 1'b0);
      if (i == 14) chk("fill_full_15", 64'(out_fifo_full), 64'd0);
    end
    chk("fill_full_16", 64'(out_fifo_full), 64'd1);
    chk("fill_ovf_pre", 64'(overflow), 64'd0);
    push(64'd9999, 1'b0);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_full_17", 64'(out_fifo_full), 64'd1);
    out_fifo_read = 1'b1;
    for (int n = 0; n < 64; n++) begin
      chk("fill_data", out_fifo_data, 64'(1000 + n));
      chk("fill_last", 64'(out_fifo_last), 64'd0);
      step();
    end
    out_fifo_read = 1'b0;
    chk("fill_empty_after", 64'(out_fifo_empty), 64'd1);
    chk("fill_full_after", 64'(out_fifo_full), 64'd0);
    chk("fill_ovf_sticky", 64'(overflow), 64'd1);
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Steady state around 8 entries: push every 4th cycle, read continuously
    for (int j = 0; j < 8; j++) push(64'(2000 + 4 * j), 1'b0);
    for (int c = 0; c < 160; c++) begin
      out_fifo_read = 1'b1;
      fifo_write    = (c % 4 == 0);
      fifo_data     = mk(64'(2000 + 4 * (8 + c / 4)));
      chk("steady_data", out_fifo_data, 64'(2000 + c));
      chk("steady_full", 64'(out_fifo_full), 64'd0);
      step();
    end
    fifo_write = 1'b0;
    for (int c = 160; c < 192; c++) begin
      chk("steady_drain", out_fifo_data, 64'(2000 + c));
      step();
    end
    out_fifo_read = 1'b0;
    chk("steady_empty", 64'(out_fifo_empty), 64'd1);
    chk("steady_ovf", 64'(overflow), 64'd0);

    // Send-only pulse flags only the most recent entry
    push(64'd3000, 1'b0);
    push(64'd3004, 1'b0);
    push(64'd3008, 1'b0);
    fifo_send = 1'b1;
    step();
    fifo_send = 1'b0;
    out_fifo_read = 1'b1;
    for (int n = 0; n < 12; n++) begin
      chk("sendonly_data", out_fifo_data, 64'(3000 + n));
      chk("sendonly_last", 64'(out_fifo_last), 64'(n == 11));
      step();
    end
    out_fifo_read = 1'b0;
    chk("sendonly_empty", 64'(out_fifo_empty), 64'd1);

    // Send on an empty buffer is ignored
    fifo_send = 1'b1;
    step();
    fifo_send = 1'b0;
    push(64'd3100, 1'b0);
    out_fifo_read = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk("sendempty_data", out_fifo_data, 64'(3100 + n));
      chk("sendempty_last", 64'(out_fifo_last), 64'd0);
      step();
    end
    out_fifo_read = 1'b0;
    chk("sendempty_empty", 64'(out_fifo_empty), 64'd1);

    // Reset while lane 2 is presented
    push(64'd4000, 1'b1);
    out_fifo_read = 1'b1;
    step();
    step();
    chk("midrst_lane2", out_fifo_data, 64'd4002);
    reset_reset = 1'b1;
    step();
    reset_reset   = 1'b0;
    out_fifo_read = 1'b0;
    chk("midrst_empty", 64'(out_fifo_empty), 64'd1);
    chk("midrst_data",  out_fifo_data, 64'd0);
    chk("midrst_full",  64'(out_fifo_full), 64'd0);
    chk("midrst_ovf",   64'(overflow), 64'd0);
    chk("midrst_last",  64'(out_fifo_last), 64'd0);
    push(64'd4100, 1'b1);
    chk("postrst_empty", 64'(out_fifo_empty), 64'd0);
    out_fifo_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("postrst_data", out_fifo_data, 64'(4100 + k));
      chk("postrst_last", 64'(out_fifo_last), 64'(k == 3));
      step();
    end
    out_fifo_read = 1'b0;
    chk("postrst_empty_after", 64'(out_fifo_empty), 64'd1);

`ifdef PACKET_GATE_EN
    // Gate holds until the packet completes, then full buffer escape
    push(64'd5000, 1'b0);
    push(64'd5004, 1'b0);
    chk("gate_closed", 64'(out_fifo_empty), 64'd1);
    fifo_send = 1'b1;
    step();
    fifo_send = 1'b0;
    chk("gate_open", 64'(out_fifo_empty), 64'd0);
    out_fifo_read = 1'b1;
    for (int n = 0; n < 8; n++) begin
      chk("gate_data", out_fifo_data, 64'(5000 + n));
      step();
    end
    out_fifo_read = 1'b0;
    chk("gate_drained", 64'(out_fifo_empty), 64'd1);
    for (int i = 0; i < 16; i++) begin
      push(64'(6000 + 4 * i), 1'b0);
      if (i == 14) chk("gate_esc_closed", 64'(out_fifo_empty), 64'd1);
    end
    chk("gate_esc_open", 64'(out_fifo_empty), 64'd0);
    chk("gate_esc_data", out_fifo_data, 64'd6000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
